// File: rtl/br_resolve_queue.sv
// br_resolve_queue: resolves branch/jump outcomes and buffers results in a FIFO toward the CDB
module br_resolve_queue #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic [ROB_W-1:0] in_rob,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROB_W-1:0] out_rob,
  output logic [XLEN-1:0]  out_rd_data,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_target,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispred
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  rd;
    logic             taken;
    logic             mis;
    logic [XLEN-1:0]  tgt;
  } ent_t;
  ent_t             mem_q [DEPTH];
  ent_t             mem_d [DEPTH];
  ent_t             ent;
  ent_t             head;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] br_q, br_d, mis_q, mis_d;
  logic             legal, taken, jump, push, pop;
  logic [XLEN-1:0]  pc4, dest;
  // resolve the incoming op: direction, target, link value and prediction check
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (in_op)
      4'd0: taken = in_rs1 == in_rs2;
      4'd1: taken = in_rs1 != in_rs2;
      4'd4: taken = $signed(in_rs1) < $signed(in_rs2);
      4'd5: taken = $signed(in_rs1) >= $signed(in_rs2);
      4'd6: taken = in_rs1 < in_rs2;
      4'd7: taken = in_rs1 >= in_rs2;
      4'd8, 4'd9: taken = 1'b1;
      default: legal = 1'b0;
    endcase
    jump = in_op == 4'd8 || in_op == 4'd9;
    pc4 = in_pc + XLEN'(4);
    dest = in_op == 4'd9 ? (in_rs1 + in_imm) & {{(XLEN-1){1'b1}}, 1'b0} : in_pc + in_imm;
    ent.rob = in_rob;
    ent.rd = jump ? pc4 : '0;
    ent.taken = taken;
    ent.tgt = taken ? dest : pc4;
    ent.mis = legal & ((taken != in_pred_taken) | (taken & in_pred_taken & (dest != in_pred_target)));
  end
  // handshake, FIFO pointer/count and saturating counter next-state
  always_comb begin
    out_valid = cnt_q != '0;
    in_ready = !flush && (cnt_q < FULL || (out_valid && out_ready));
    push = in_valid && in_ready;
    pop = out_valid && out_ready && !flush;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = ent;
    wr_d = wr_q + PW'(push);
    rd_d = flush ? wr_q : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    br_d = push && !(&br_q) ? br_q + 1'b1 : br_q;
    mis_d = push && ent.mis && !(&mis_q) ? mis_q + 1'b1 : mis_q;
  end
  // head presentation; data forced to zero while the FIFO is empty
  always_comb begin
    head = mem_q[rd_q];
    out_rob = out_valid ? head.rob : '0;
    out_rd_data = out_valid ? head.rd : '0;
    out_taken = out_valid && head.taken;
    out_mispredict = out_valid && head.mis;
    out_target = out_valid ? head.tgt : '0;
    perf_branches = br_q;
    perf_mispred = mis_q;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      br_q <= '0;
      mis_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
      mis_q <= mis_d;
    end
  end
endmodule
